// File: rtl/riscv_pipe_pkg.sv
// Shared widths and control encodings for the RV32 pipeline registers.
package riscv_pipe_pkg;

    localparam int unsigned XLEN_DEF      = 32;
    localparam int unsigned REGN_W_DEF    = 5;
    localparam int unsigned ALUCTRL_W_DEF = 4;
    localparam int unsigned RESSRC_W_DEF  = 2;
    localparam int unsigned CNT_W_DEF     = 16;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } res_src_e;

    typedef struct packed {
        logic    branch;
        logic    jump;
        alu_op_e alu_ctrl;
        logic    alu_src;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic     reg_write;
        res_src_e result_src;
    } wb_ctrl_t;

endpackage

// File: rtl/pipe_field_reg.sv
// Field-group flop: async active-low reset, synchronous clear (bubble), load enable.
module pipe_field_reg #(
    parameter int unsigned    W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Clear outranks enable so a flush lands even while the stage is stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RST_VAL;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with stall/flush, valid gating of side effects
// and a saturating count of bubbles loaded into the E stage.
module id_ex_pipe_reg
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter int unsigned REGN_W    = REGN_W_DEF,
    parameter int unsigned ALUCTRL_W = ALUCTRL_W_DEF,
    parameter int unsigned RESSRC_W  = RESSRC_W_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stallE,
    input  logic                 flushE,
    input  logic                 validD,
    input  logic [XLEN-1:0]      pcD,
    input  logic [REGN_W-1:0]    rs1nD,
    input  logic [REGN_W-1:0]    rs2nD,
    input  logic [REGN_W-1:0]    rdnD,
    input  logic [XLEN-1:0]      rs1D,
    input  logic [XLEN-1:0]      rs2D,
    input  logic [XLEN-1:0]      immD,
    input  logic                 RegWriteD,
    input  logic [RESSRC_W-1:0]  ResultSrcD,
    input  logic                 MemWriteD,
    input  logic                 BranchD,
    input  logic                 JumpD,
    input  logic [ALUCTRL_W-1:0] ALUControlD,
    input  logic                 ALUSrcD,
    output logic                 validE,
    output logic [XLEN-1:0]      pcE,
    output logic [REGN_W-1:0]    rs1nE,
    output logic [REGN_W-1:0]    rs2nE,
    output logic [REGN_W-1:0]    rdnE,
    output logic [XLEN-1:0]      rs1E,
    output logic [XLEN-1:0]      rs2E,
    output logic [XLEN-1:0]      immE,
    output logic                 RegWriteE,
    output logic [RESSRC_W-1:0]  ResultSrcE,
    output logic                 MemWriteE,
    output logic                 BranchE,
    output logic                 JumpE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic [CNT_W-1:0]     bubble_cnt
);

    localparam int unsigned DATA_W = 4 * XLEN;
    localparam int unsigned IDX_W  = 3 * REGN_W;
    localparam int unsigned CTRL_W = 6 + RESSRC_W + ALUCTRL_W;

    logic              w_en;
    logic              w_bubble;
    logic [DATA_W-1:0] w_data_d, w_data_q;
    logic [IDX_W-1:0]  w_idx_d,  w_idx_q;
    logic [CTRL_W-1:0] w_ctrl_d, w_ctrl_q;
    logic [CNT_W-1:0]  r_bubble_cnt;

    assign w_en     = ~stallE;
    assign w_data_d = {pcD, rs1D, rs2D, immD};
    assign w_idx_d  = {rs1nD, rs2nD, rdnD};

    // Side-effect controls only survive for a real instruction; x0 writes are dropped here.
    assign w_ctrl_d = {validD,
                       RegWriteD & validD & (rdnD != '0),
                       ResultSrcD,
                       MemWriteD & validD,
                       BranchD & validD,
                       JumpD & validD,
                       ALUControlD,
                       ALUSrcD};

    pipe_field_reg #(.W(DATA_W), .RST_VAL('0)) u_data (
        .i_clk(clk), .i_rst_n(rst), .i_en(w_en), .i_clr(flushE),
        .i_d(w_data_d), .o_q(w_data_q)
    );

    pipe_field_reg #(.W(IDX_W), .RST_VAL('0)) u_idx (
        .i_clk(clk), .i_rst_n(rst), .i_en(w_en), .i_clr(flushE),
        .i_d(w_idx_d), .o_q(w_idx_q)
    );

    pipe_field_reg #(.W(CTRL_W), .RST_VAL('0)) u_ctrl (
        .i_clk(clk), .i_rst_n(rst), .i_en(w_en), .i_clr(flushE),
        .i_d(w_ctrl_d), .o_q(w_ctrl_q)
    );

    assign {pcE, rs1E, rs2E, immE} = w_data_q;
    assign {rs1nE, rs2nE, rdnE}    = w_idx_q;
    assign {validE, RegWriteE, ResultSrcE, MemWriteE, BranchE, JumpE,
            ALUControlE, ALUSrcE}  = w_ctrl_q;

    // A bubble enters E on a flush (even when stalled) or on an unstalled load of an empty slot.
    assign w_bubble = flushE | (~stallE & ~validD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign bubble_cnt = r_bubble_cnt;

endmodule
